// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped read cache with a blocking line refill, whole-cache flush
// and saturating hit/miss statistics.
module dm_cache_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int LINES  = 1024,
    parameter int CNT_W  = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  cpu_req_i,
    input  logic [ADDR_W-1:0]                     cpu_addr_i,
    input  logic                                  flush_i,
    output logic                                  cpu_ready_o,
    output logic                                  cpu_rvalid_o,
    output logic [DATA_W-1:0]                     cpu_rdata_o,
    output logic                                  miss_o,
    output logic                                  mem_req_o,
    output logic [ADDR_W-$clog2(WORDS)-1:0]       mem_addr_o,
    input  logic                                  mem_ack_i,
    input  logic [WORDS*DATA_W-1:0]               mem_rdata_i,
    output logic [CNT_W-1:0]                      hit_count_o,
    output logic [CNT_W-1:0]                      miss_count_o
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_e;

    state_e                       state_q, state_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [DATA_W-1:0]            rdata_q, rdata_d;
    logic [CNT_W-1:0]             hit_q, hit_d, miss_q, miss_d;
    logic [LINES-1:0]             valid_q, valid_d;
    logic [WORDS-1:0][DATA_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]             tag_q [LINES];
    logic [WORDS-1:0][DATA_W-1:0] line_q, mem_words;
    logic [TAG_W-1:0]             rd_tag_q;
    logic                         rd_vld_q;
    logic [OFF_W-1:0]             off;
    logic [IDX_W-1:0]             idx, cpu_idx;
    logic [TAG_W-1:0]             tag;
    logic                         accept, hit;

    assign mem_words    = mem_rdata_i;
    assign off          = addr_q[OFF_W-1:0];
    assign idx          = addr_q[OFF_W +: IDX_W];
    assign tag          = addr_q[ADDR_W-1 -: TAG_W];
    assign cpu_idx      = cpu_addr_i[OFF_W +: IDX_W];
    assign accept       = state_q == IDLE && cpu_req_i && !flush_i;
    assign hit          = rd_vld_q && rd_tag_q == tag;
    assign cpu_ready_o  = state_q == IDLE && rst_ni;
    assign mem_req_o    = state_q == REFILL;
    assign mem_addr_o   = addr_q[ADDR_W-1:OFF_W];
    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data arrays carry no reset; the lookup reads them one cycle ahead of the compare.
    always_ff @(posedge clk_i) begin
        if (state_q == REFILL && mem_ack_i) begin
            data_q[idx] <= mem_words;
            tag_q[idx]  <= tag;
        end
        if (accept) begin
            line_q   <= data_q[cpu_idx];
            rd_tag_q <= tag_q[cpu_idx];
            rd_vld_q <= valid_q[cpu_idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        valid_d      = valid_q;
        cpu_rvalid_o = 1'b0;
        miss_o       = 1'b0;
        cpu_rdata_o  = rdata_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    valid_d = '0;
                end else if (cpu_req_i) begin
                    addr_d  = cpu_addr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_rvalid_o = 1'b1;
                    cpu_rdata_o  = line_q[off];
                    rdata_d      = line_q[off];
                    hit_d        = hit_q + CNT_W'(hit_q != '1);
                    state_d      = IDLE;
                end else begin
                    miss_o  = 1'b1;
                    miss_d  = miss_q + CNT_W'(miss_q != '1);
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    valid_d[idx] = 1'b1;
                    rdata_d      = mem_words[off];
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                cpu_rvalid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: randomized scoreboard bench for dm_cache_ctrl against a line-level cache model,
// plus a small-geometry instance for counter saturation and wide-line word select.
module tb_dm_cache_ctrl;
    logic clk = 1'b0, rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic         cpu_req = 1'b0, flush = 1'b0, mem_ack = 1'b0;
    logic [14:0]  cpu_addr = '0;
    logic [127:0] mem_rdata = '0;
    logic         cpu_ready, cpu_rvalid, miss, mem_req;
    logic [31:0]  cpu_rdata;
    logic [12:0]  mem_addr;
    logic [15:0]  hit_count, miss_count;

    dm_cache_ctrl u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .flush_i(flush),
        .cpu_ready_o(cpu_ready), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .miss_o(miss),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    logic         s_req = 1'b0, s_mem_ack = 1'b0;
    logic [14:0]  s_addr = '0;
    logic [255:0] s_mem_rdata = '0;
    logic         s_ready, s_rvalid, s_miss, s_mem_req;
    logic [31:0]  s_rdata;
    logic [11:0]  s_mem_addr;
    logic [1:0]   s_hits, s_misses;

    dm_cache_ctrl #(.WORDS(8), .LINES(16), .CNT_W(2)) u_small (
        .clk_i(clk), .rst_ni(rst_ni), .cpu_req_i(s_req), .cpu_addr_i(s_addr), .flush_i(1'b0),
        .cpu_ready_o(s_ready), .cpu_rvalid_o(s_rvalid), .cpu_rdata_o(s_rdata), .miss_o(s_miss),
        .mem_req_o(s_mem_req), .mem_addr_o(s_mem_addr), .mem_ack_i(s_mem_ack), .mem_rdata_i(s_mem_rdata),
        .hit_count_o(s_hits), .miss_count_o(s_misses)
    );

    typedef struct {logic [31:0] data; bit hit; int acc;} item_t;
    item_t       sb[$];
    item_t       it;
    int          checks = 0, failures = 0, cyc = 0, done_cnt = 0, last_l = 0, ack_force = 0;
    int          rq = 0, tgt = 1, s_miss_seen = 0;
    bit          mv[1024];
    int          mtag[1024];
    int          exp_hits = 0, exp_miss = 0;
    bit          exp_refill = 1'b0;
    logic [12:0] exp_line = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Backing memory contents: line 1 holds {0xD,0xC,0xB,0xA}, every other line a tagged pattern.
    function automatic logic [31:0] mw(input logic [12:0] l, input int k);
        return l == 13'd1 ? 32'hA + 32'(k) : {l, 3'b0, 8'(k), 8'h5A};
    endfunction

    function automatic logic [127:0] mline(input logic [12:0] l);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = mw(l, k);
        return r;
    endfunction

    function automatic logic [31:0] sw(input logic [11:0] l, input int k);
        return {l, 12'(k), 8'hC3};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory side: random refill latency (or forced), spurious acks while no request is pending.
    always @(negedge clk) begin
        if (mem_req) begin
            rq++;
            if (rq == 1) tgt = ack_force != 0 ? ack_force : $urandom_range(1, 4);
            chk("mem_req_expected", exp_refill, 1);
            chk("mem_addr", mem_addr, exp_line);
            mem_ack   = rq == tgt;
            mem_rdata = rq == tgt ? mline(mem_addr) : '0;
            if (rq == tgt) last_l = rq;
        end else begin
            rq        = 0;
            mem_ack   = $urandom_range(0, 3) == 0;
            mem_rdata = {4{$urandom}};
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (miss) begin
                if (sb.size() == 0) chk("miss_unexpected", 1, 0);
                else begin
                    chk("miss_vs_model", 0, sb[0].hit);
                    chk("miss_latency", cyc - sb[0].acc + 1, 1);
                end
            end
            if (cpu_rvalid) begin
                if (sb.size() == 0) chk("rvalid_unexpected", 1, 0);
                else begin
                    it = sb.pop_front();
                    chk("rdata", cpu_rdata, it.data);
                    chk("rvalid_latency", cyc - it.acc + 1, it.hit ? 1 : 2 + last_l);
                    exp_refill = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        s_mem_ack = s_mem_req;
        for (int k = 0; k < 8; k++) s_mem_rdata[k*32 +: 32] = sw(s_mem_addr, k);
        if (s_miss) s_miss_seen++;
    end

    task automatic clear_model();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a);
        item_t t;
        int idx, tg, d0;
        idx   = int'(a[11:2]);
        tg    = int'(a[14:12]);
        t.hit  = mv[idx] && mtag[idx] == tg;
        t.data = mw(a[14:2], int'(a[1:0]));
        t.acc  = cyc + 1;
        if (t.hit) exp_hits++;
        else begin
            exp_miss++;
            mv[idx]    = 1'b1;
            mtag[idx]  = tg;
            exp_line   = a[14:2];
            exp_refill = 1'b1;
        end
        sb.push_back(t);
        d0 = done_cnt;
        cpu_addr = a;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        for (int i = 0; i < 40 && done_cnt == d0; i++) @(posedge clk);
        #1;
        if (done_cnt == d0) begin
            chk("response_timeout", 1, 0);
            sb.delete();
            exp_refill = 1'b0;
        end
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_miss);
        chk("rdata_hold", cpu_rdata, t.data);
        chk("ready_after_resp", cpu_ready, 1);
    endtask

    task automatic do_flush(input bit with_req, input logic [14:0] a);
        flush    = 1'b1;
        cpu_req  = with_req;
        cpu_addr = a;
        @(posedge clk);
        #1 flush = 1'b0;
        cpu_req = 1'b0;
        clear_model();
        chk("flush_not_accepted", cpu_ready, 1);
        chk("flush_hit_count", hit_count, exp_hits);
        chk("flush_miss_count", miss_count, exp_miss);
    endtask

    task automatic sread(input logic [14:0] a, input logic [31:0] exp);
        bit got;
        got    = 1'b0;
        s_addr = a;
        s_req  = 1'b1;
        @(posedge clk);
        #1 s_req = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = s_rvalid;
        end
        chk("s_rvalid_seen", got, 1);
        chk("s_rdata", s_rdata, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        item_t ti;
        logic [14:0] a;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_low", cpu_ready, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_miss", miss, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_counts", {hit_count, miss_count}, 0);
        rst_ni = 1'b1;
        #1 chk("ready_after_rst", cpu_ready, 1);
        @(posedge clk);
        #1;
        ack_force = 3;
        rd(15'h0005);
        ack_force = 0;
        rd(15'h0004);
        rd(15'h0006);
        rd(15'h0007);
        rd(15'h1005);
        rd(15'h0005);
        do_flush(1'b1, 15'h1005);
        rd(15'h1005);

        // Reset two cycles into a refill that the memory never acknowledges.
        do_flush(1'b0, 15'h0);
        ack_force  = 50;
        ti.hit     = 1'b0;
        ti.data    = mw(13'h0123, 2);
        ti.acc     = cyc + 1;
        exp_miss++;
        exp_line   = 13'h0123;
        exp_refill = 1'b1;
        sb.push_back(ti);
        cpu_addr = {13'h0123, 2'd2};
        cpu_req  = 1'b1;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("mem_req_before_rst", mem_req, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_drops_mem_req", mem_req, 0);
        chk("rst_ready_low2", cpu_ready, 0);
        chk("rst_rdata2", cpu_rdata, 0);
        chk("rst_mem_addr2", mem_addr, 0);
        chk("rst_counts2", {hit_count, miss_count}, 0);
        sb.delete();
        clear_model();
        exp_refill = 1'b0;
        exp_hits   = 0;
        exp_miss   = 0;
        ack_force  = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst2", cpu_ready, 1);
        rd(15'h0005);

        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(0, 7) == 0 ? 15'($urandom)
                : {3'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 19) == 0) do_flush(1'($urandom_range(0, 1)), a);
            else rd(a);
        end

        sread(15'h7FFF, sw(12'hFFF, 7));
        chk("s_mem_addr", s_mem_addr, 12'hFFF);
        for (int k = 0; k < 5; k++) sread(15'h7FF8 + 15'(k), sw(12'hFFF, k));
        chk("s_hit_saturated", s_hits, 3);
        chk("s_miss_count", s_misses, 1);
        chk("s_miss_pulses", s_miss_seen, 1);
        chk("s_ready", s_ready, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
